// File: rtl/sdram_burst_port_if.sv
// Bundles the host-side command/data ports and the sdram_controller request/ack
// ports of sdram_burst_port. "slave" is the port's own view; "master" is the
// view of whatever drives it (host plus controller, e.g. a testbench).
//
// Handshakes: cmd, wr and rd transfer a word on any clock edge where both
// valid and ready are high; valid never waits on ready, and ready may depend
// on state only. The sdram_* req/ack pair follows the controller's contract:
// req is held until ack rises, then ack stays high for the burst length.
interface sdram_burst_port_if #(
    parameter int AW = 24
);
    logic          sdram_init_done;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [9:0]    cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [15:0]   wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [15:0]   rd_data;
    logic          busy;
    logic          err;
    logic          sdram_wr_req;
    logic          sdram_wr_ack;
    logic [AW-1:0] sdram_wr_addr;
    logic [9:0]    sdram_wr_burst;
    logic [15:0]   sdram_din;
    logic          sdram_rd_req;
    logic          sdram_rd_ack;
    logic [AW-1:0] sdram_rd_addr;
    logic [9:0]    sdram_rd_burst;
    logic [15:0]   sdram_dout;
    logic [2:0]    state_dbg;

    modport slave (
        input  sdram_init_done, cmd_valid, cmd_wr, cmd_addr, cmd_len,
               wr_valid, wr_data, rd_ready, sdram_wr_ack, sdram_rd_ack, sdram_dout,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy, err,
               sdram_wr_req, sdram_wr_addr, sdram_wr_burst, sdram_din,
               sdram_rd_req, sdram_rd_addr, sdram_rd_burst, state_dbg
    );

    modport master (
        output sdram_init_done, cmd_valid, cmd_wr, cmd_addr, cmd_len,
               wr_valid, wr_data, rd_ready, sdram_wr_ack, sdram_rd_ack, sdram_dout,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy, err,
               sdram_wr_req, sdram_wr_addr, sdram_wr_burst, sdram_din,
               sdram_rd_req, sdram_rd_addr, sdram_rd_burst, state_dbg
    );
endinterface

// File: rtl/sdram_burst_port.sv
// Burst command front end for sdram_controller. One command at a time:
// write bursts are staged in a show-ahead write FIFO until len words are
// present, read bursts wait for len free slots in the read FIFO, then the
// controller req/ack handshake is sequenced. FSM state is exported on
// bus.state_dbg.
// Optional: define SDRAM_BURST_PORT_TIMEOUT_EN to abort a request that sees
// no ack within TIMEOUT cycles (err pulse, write words discarded).
module sdram_burst_port #(
    parameter int DEPTH   = 16,
    parameter int AW      = 24,
    parameter int TIMEOUT = 1023
) (
    input logic               clk,
    input logic               rst,
    sdram_burst_port_if.slave bus
);
    localparam int PW = $clog2(DEPTH) + 1;  // pointer width, wraps mod 2*DEPTH
    localparam int IW = PW - 1;              // storage index width

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WFILL  = 3'd1,
        WREQ   = 3'd2,
        WBURST = 3'd3,
        RWAIT  = 3'd4,
        RREQ   = 3'd5,
        RBURST = 3'd6
    } state_t;

    state_t state, state_nxt;

    // Direction is carried by the state encoding, so only addr/len are kept.
    logic [AW-1:0] addr_q;
    logic [9:0]    len_q;
    logic          err_q;
    logic          cmd_fire, cmd_legal, tmo_hit;

    logic [15:0]   wf_mem [DEPTH];
    logic [PW-1:0] wf_wptr, wf_rptr, wf_count;
    logic          wf_full, wf_empty, wf_push, wf_pop, wf_drop, wf_fill_ok;
    logic [15:0]   din_last;

    logic [15:0]   rf_mem [DEPTH];
    logic [PW-1:0] rf_wptr, rf_rptr, rf_count;
    logic          rf_full, rf_empty, rf_push, rf_pop, rf_room_ok;

    assign cmd_fire  = bus.cmd_valid & bus.cmd_ready;
    assign cmd_legal = (bus.cmd_len != 10'd0) && (bus.cmd_len <= 10'(DEPTH));

    // Write FIFO: pops on every controller ack cycle of a write burst
    // (including the ack-rise cycle seen in WREQ); an empty pop is ignored.
    assign wf_count   = wf_wptr - wf_rptr;
    assign wf_full    = (wf_count == PW'(DEPTH));
    assign wf_empty   = (wf_count == '0);
    assign wf_push    = bus.wr_valid & ~wf_full;
    assign wf_pop     = ((state == WREQ) || (state == WBURST)) & bus.sdram_wr_ack & ~wf_empty;
    assign wf_fill_ok = ({1'b0, len_q} <= 11'(wf_count));

    // Read FIFO: pushes every ack cycle of a read burst; RWAIT guarantees
    // room, the pop term only covers the legal push-at-full-with-pop case.
    assign rf_count   = rf_wptr - rf_rptr;
    assign rf_full    = (rf_count == PW'(DEPTH));
    assign rf_empty   = (rf_count == '0);
    assign rf_pop     = ~rf_empty & bus.rd_ready;
    assign rf_push    = ((state == RREQ) || (state == RBURST)) & bus.sdram_rd_ack
                        & (~rf_full | rf_pop);
    assign rf_room_ok = ({1'b0, len_q} <= (11'(DEPTH) - 11'(rf_count)));

`ifdef SDRAM_BURST_PORT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // Ack-wait watchdog: counts while requesting, zero in every other state
    always_ff @(posedge clk) begin
        if (rst || !((state == WREQ) || (state == RREQ))) tmo_cnt <= '0;
        else                                               tmo_cnt <= tmo_cnt + TW'(1);
    end

    assign tmo_hit = (((state == WREQ) && !bus.sdram_wr_ack) ||
                      ((state == RREQ) && !bus.sdram_rd_ack)) &&
                     (tmo_cnt == TW'(TIMEOUT - 1));
    assign wf_drop = tmo_hit && (state == WREQ);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign tmo_hit = 1'b0;
    assign wf_drop = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire && cmd_legal) state_nxt = bus.cmd_wr ? WFILL : RWAIT;
            WFILL:   if (wf_fill_ok) state_nxt = WREQ;
            WREQ:    if (bus.sdram_wr_ack) state_nxt = WBURST;
                     else if (tmo_hit)     state_nxt = IDLE;
            WBURST:  if (!bus.sdram_wr_ack) state_nxt = IDLE;
            RWAIT:   if (rf_room_ok) state_nxt = RREQ;
            RREQ:    if (bus.sdram_rd_ack) state_nxt = RBURST;
                     else if (tmo_hit)     state_nxt = IDLE;
            RBURST:  if (!bus.sdram_rd_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch and one-cycle error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            len_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                addr_q <= bus.cmd_addr;
                len_q  <= bus.cmd_len;
            end
            err_q <= (cmd_fire && !cmd_legal) || tmo_hit;
        end
    end

    // Write FIFO storage (contents need no reset, pointers define validity)
    always_ff @(posedge clk) begin
        if (wf_push) wf_mem[wf_wptr[IW-1:0]] <= bus.wr_data;
    end

    // Write FIFO pointers and last-popped word for over-long ack
    always_ff @(posedge clk) begin
        if (rst) begin
            wf_wptr  <= '0;
            wf_rptr  <= '0;
            din_last <= '0;
        end else begin
            if (wf_push) wf_wptr <= wf_wptr + PW'(1);
            if (wf_pop) begin
                wf_rptr  <= wf_rptr + PW'(1);
                din_last <= wf_mem[wf_rptr[IW-1:0]];
            end else if (wf_drop) begin
                wf_rptr  <= wf_rptr + PW'(len_q);
            end
        end
    end

    // Read FIFO storage
    always_ff @(posedge clk) begin
        if (rf_push) rf_mem[rf_wptr[IW-1:0]] <= bus.sdram_dout;
    end

    // Read FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wptr <= '0;
            rf_rptr <= '0;
        end else begin
            if (rf_push) rf_wptr <= rf_wptr + PW'(1);
            if (rf_pop)  rf_rptr <= rf_rptr + PW'(1);
        end
    end

    assign bus.cmd_ready      = (state == IDLE) & bus.sdram_init_done;
    assign bus.wr_ready       = ~wf_full;
    assign bus.rd_valid       = ~rf_empty;
    assign bus.rd_data        = rf_mem[rf_rptr[IW-1:0]];
    assign bus.busy           = (state != IDLE);
    assign bus.err            = err_q;
    assign bus.sdram_wr_req   = (state == WREQ);
    assign bus.sdram_wr_addr  = addr_q;
    assign bus.sdram_wr_burst = len_q;
    assign bus.sdram_din      = wf_empty ? din_last : wf_mem[wf_rptr[IW-1:0]];
    assign bus.sdram_rd_req   = (state == RREQ);
    assign bus.sdram_rd_addr  = addr_q;
    assign bus.sdram_rd_burst = len_q;
    assign bus.state_dbg      = state;
endmodule

// File: doc/sdram_burst_port.md
Name: sdram_burst_port

Overview:
- Command/data front end sitting directly upstream of sdram_controller; drives its write and read request/ack ports.
- Accepts one burst command at a time from a register-style host (UART MCU pins or a DMA master).
- Buffers write words in a show-ahead FIFO and returns read words through a second FIFO.
- Sequences the controller's req/ack handshake so the host never sees SDRAM timing.

Parameters:
- DEPTH, 16, words per FIFO (power of two, ≥2); also the maximum legal burst length.
- AW, 24, SDRAM word address width.
- TIMEOUT, 1023, ack-wait watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  controller clock (100 MHz ref clock shared with sdram_controller).
- rst  in  1  synchronous, active-high reset.
- sdram_init_done  in  1  from controller; no command is issued while 0.
- cmd_valid  in  1  command offer.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_wr  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  AW  start address.
- cmd_len  in  10  burst length in words.
- wr_valid / wr_ready  in/out  1  write-data push handshake.
- wr_data  in  16  write word.
- rd_valid / rd_ready  out/in  1  read-data pop handshake.
- rd_data  out  16  read word (show-ahead FIFO head).
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse on a rejected command or timeout.
- sdram_wr_req  out  1  to controller.
- sdram_wr_ack  in  1  from controller.
- sdram_wr_addr  out  AW  to controller.
- sdram_wr_burst  out  10  to controller.
- sdram_din  out  16  to controller.
- sdram_rd_req  out  1  to controller.
- sdram_rd_ack  in  1  from controller.
- sdram_rd_addr  out  AW  to controller.
- sdram_rd_burst  out  10  to controller.
- sdram_dout  in  16  from controller.

Behaviour:
- Reset:
  - State goes to IDLE and both FIFOs are flushed.
  - req outputs, busy, err, rd_valid = 0; wr_ready = 1; addr/burst registers = 0.
  - Mid-burst reset drops req on the next edge; the partial burst is abandoned.
- Controller contract:
  - Controller asserts ack for exactly the burst-length consecutive cycles.
  - Write: sdram_din is consumed on every ack cycle, so the FIFO pops each ack cycle and sdram_din always shows the FIFO head.
  - Read: sdram_dout is valid on every rd_ack cycle and is pushed into the read FIFO that cycle.
- cmd_ready = (state==IDLE) & sdram_init_done.
- On accept, addr, len and direction are latched.
  - len==0 or len>DEPTH: command is dropped, err pulses the next cycle, state stays IDLE.
- States:
  - IDLE: on legal write go to WFILL; on legal read go to RWAIT.
  - WFILL: wait until write-FIFO count ≥ len, then go to WREQ. There is no deadline on host data.
  - WREQ: sdram_wr_req=1 until sdram_wr_ack rises, then go to WBURST.
  - WBURST: req=0; pop each ack cycle. When ack falls, go to IDLE.
    - If ack lasts longer than len cycles, extra pops are ignored on an empty FIFO and din holds the last word.
  - RWAIT: wait until read-FIFO free space ≥ len, then go to RREQ. This guarantees no read overflow.
  - RREQ: sdram_rd_req=1 until sdram_rd_ack rises, then go to RBURST. The ack-rise cycle's data is pushed.
  - RBURST: push while ack is high; on ack fall go to IDLE.
- sdram_wr_burst / sdram_rd_burst = latched len; addresses are held stable for the whole command.
- Write FIFO:
  - wr_ready = !full.
  - Push and pop in the same cycle keeps the count unchanged, including at full.
  - Pushes are allowed in any state.
- Read FIFO:
  - rd_valid = !empty.
  - Simultaneous push and pop is legal at full and at empty (at empty, the word appears the next cycle).
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH; count = wptr − rptr.
- Latency: from ack high, a read word is visible on rd_data 1 cycle later.

Optional Feature:
- Macro SDRAM_BURST_PORT_TIMEOUT_EN.
- Defined:
  - A counter runs in WREQ/RREQ, cleared on state entry.
  - On reaching TIMEOUT without ack: req drops, err pulses, state goes to IDLE.
  - For a write timeout, len words are discarded from the write FIFO.
- Undefined: no counter; WREQ/RREQ wait indefinitely and the TIMEOUT parameter is unused.

Test Plan:
- Write len=4 at addr 0x000100:
  - Push 0x1111,0x2222,0x3333,0x4444 → wr_req rises only after the 4th push.
  - With ack held 4 cycles, sdram_din=0x1111..0x4444 on successive ack cycles; busy falls after ack falls.
- Read len=4 at 0x000100:
  - Controller returns 0xA0..0xA3 on 4 ack cycles → rd_data delivers 0xA0,0xA1,0xA2,0xA3 in order.
  - rd_valid first high 1 cycle after ack rises.
- Read len=16 with the read FIFO holding 1 unpopped word → rd_req stays 0 until the word is popped, then asserts.
- cmd_len=0 and cmd_len=17 → each accepted for 1 cycle; err pulses; no req; state IDLE.
- Reset asserted 2 cycles into a write burst → req=0 and FIFOs empty next cycle; a following read command completes normally.
- With TIMEOUT_EN and TIMEOUT=8, no ack → rd_req high exactly 8 cycles, then err pulse and busy=0.
